// File: rtl/test_tile_rx_checker.sv
// Receive-side checker tile for mesh all-to-all tests.
// Accepts packets from the router's local output, injects LFSR-driven
// backpressure, checks destination and per-source sequence ordering, and
// flags completion once every source has delivered its quota.

// Per-source expected-sequence tracker; one instance per source tile.
module test_tile_rx_src_trk #(
  parameter int seq_width_p       = 8,
  parameter int packets_per_src_p = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   hit_i,
  input  logic [seq_width_p-1:0] seq_i,
  output logic                   order_err_o,
  output logic                   ovf_err_o,
  output logic                   complete_nxt_o
);

  localparam logic [seq_width_p-1:0] quota_lp = seq_width_p'(packets_per_src_p);
  localparam logic [seq_width_p-1:0] last_lp  = seq_width_p'(packets_per_src_p - 1);
  localparam logic [seq_width_p-1:0] one_lp   = seq_width_p'(1);

  logic [seq_width_p-1:0] exp_seq_r;
  logic                   full;

  assign full           = (exp_seq_r == quota_lp);
  assign order_err_o    = hit_i & (seq_i != exp_seq_r);
  assign ovf_err_o      = hit_i & full;
  // Looks through this cycle's update so completion lands on the same edge
  // as the final packet's error reporting.
  assign complete_nxt_o = full | (hit_i & (exp_seq_r == last_lp));

  // Advance the expected sequence on every hit until the quota is reached,
  // even when the packet itself was out of order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)          exp_seq_r <= '0;
    else if (hit_i && !full) exp_seq_r <= exp_seq_r + one_lp;
  end

endmodule

module test_tile_rx_checker #(
  parameter int x_cord_width_p    = 4,
  parameter int y_cord_width_p    = 3,
  parameter int num_tiles_x_p     = 4,
  parameter int num_tiles_y_p     = 2,
  parameter int data_width_p      = 32,
  parameter int seq_width_p       = 8,
  parameter int packets_per_src_p = 4,
  localparam int packet_width_lp  = data_width_p + x_cord_width_p + y_cord_width_p
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [x_cord_width_p-1:0]  my_x_i,
  input  logic [y_cord_width_p-1:0]  my_y_i,
  input  logic                       v_i,
  input  logic [packet_width_lp-1:0] packet_i,
  output logic                       ready_and_o,
  input  logic                       stall_en_i,
  output logic                       done_o,
  output logic                       error_o,
  output logic [15:0]                err_count_o,
  output logic [15:0]                recv_count_o
);

  localparam int num_src_lp   = num_tiles_x_p * num_tiles_y_p;
  localparam int src_width_lp = data_width_p - seq_width_p;
  localparam logic [src_width_lp-1:0] num_src_w_lp = src_width_lp'(num_src_lp);

  typedef struct packed {
    logic [data_width_p-1:0]   payload;
    logic [y_cord_width_p-1:0] y_cord;
    logic [x_cord_width_p-1:0] x_cord;
  } pkt_s;

  typedef enum logic [0:0] {eRECV, eDONE} state_e;

  pkt_s                    pkt;
  logic [src_width_lp-1:0] src;
  logic [seq_width_p-1:0]  seq;
  logic                    accept;
  logic                    dest_err;
  logic                    src_err;
  logic                    pkt_err;
  logic [7:0]              lfsr_r;
  state_e                  state_r;

  logic [num_src_lp-1:0]   hit;
  logic [num_src_lp-1:0]   order_err;
  logic [num_src_lp-1:0]   ovf_err;
  logic [num_src_lp-1:0]   complete_nxt;

  assign pkt    = packet_i;
  assign src    = pkt.payload[data_width_p-1:seq_width_p];
  assign seq    = pkt.payload[seq_width_p-1:0];
  assign accept = v_i & ready_and_o;

  assign dest_err = (pkt.x_cord != my_x_i) | (pkt.y_cord != my_y_i);
  assign src_err  = (src >= num_src_w_lp);
  // Any combination of conditions on one packet counts as a single error.
  assign pkt_err  = accept & (dest_err | src_err | (|order_err) | (|ovf_err));

  for (genvar i = 0; i < num_src_lp; i++) begin : g_src
    localparam logic [src_width_lp-1:0] id_lp = src_width_lp'(i);
    // Out-of-range sources never match, so they leave all trackers untouched.
    assign hit[i] = accept & (src == id_lp);

    test_tile_rx_src_trk #(
      .seq_width_p       (seq_width_p),
      .packets_per_src_p (packets_per_src_p)
    ) u_trk (
      .clk_i          (clk_i),
      .reset_n_i      (reset_n_i),
      .hit_i          (hit[i]),
      .seq_i          (seq),
      .order_err_o    (order_err[i]),
      .ovf_err_o      (ovf_err[i]),
      .complete_nxt_o (complete_nxt[i])
    );
  end

  // Free-running x^8+x^6+x^5+x^4+1 LFSR; ready is registered from it so
  // there is no path from v_i to ready_and_o.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lfsr_r      <= 8'h01;
      ready_and_o <= 1'b0;
    end else begin
      lfsr_r      <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
      ready_and_o <= ~(stall_en_i & (lfsr_r[1:0] == 2'b00));
    end
  end

  // Saturating receive/error counters and the sticky error flag.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      recv_count_o <= '0;
      err_count_o  <= '0;
      error_o      <= 1'b0;
    end else begin
      if (accept && (recv_count_o != 16'hFFFF)) recv_count_o <= recv_count_o + 16'd1;
      if (pkt_err) begin
        error_o <= 1'b1;
        if (err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;
      end
    end
  end

  // Completion FSM; done_o is a registered copy of being in eDONE.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= eRECV;
      done_o  <= 1'b0;
    end else begin
      case (state_r)
        eRECV: if (&complete_nxt) begin
          state_r <= eDONE;
          done_o  <= 1'b1;
        end
        eDONE: begin
          state_r <= eDONE;
          done_o  <= 1'b1;
        end
        default: begin
          state_r <= eRECV;
          done_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_test_tile_rx_checker.sv
// Scoreboard bench for test_tile_rx_checker: each driven packet pushes its
// expected post-accept counter/flag state, popped and compared on accept.
module tb_test_tile_rx_checker;

  localparam int NSRC = 8;
  localparam int PPS  = 4;
  localparam logic [3:0] MY_X = 4'd2;
  localparam logic [2:0] MY_Y = 3'd1;

  typedef struct {
    logic [15:0] recv;
    logic [15:0] errc;
    logic        errf;
    logic        done;
  } exp_t;

  logic        clk;
  logic        reset_n_i;
  logic [3:0]  my_x_i;
  logic [2:0]  my_y_i;
  logic        v_i;
  logic [38:0] packet_i;
  logic        ready_and_o;
  logic        stall_en_i;
  logic        done_o;
  logic        error_o;
  logic [15:0] err_count_o;
  logic [15:0] recv_count_o;

  int   n_vec;
  int   n_err;
  int   stalls;
  exp_t sb[$];

  int   exp_m[NSRC];
  int   recv_m;
  int   errc_m;
  bit   errf_m;
  int   perm3[4] = '{0, 2, 1, 3};

  test_tile_rx_checker dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n_i),
    .my_x_i       (my_x_i),
    .my_y_i       (my_y_i),
    .v_i          (v_i),
    .packet_i     (packet_i),
    .ready_and_o  (ready_and_o),
    .stall_en_i   (stall_en_i),
    .done_o       (done_o),
    .error_o      (error_o),
    .err_count_o  (err_count_o),
    .recv_count_o (recv_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit all_done_m();
    for (int i = 0; i < NSRC; i++) if (exp_m[i] != PPS) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NSRC; i++) exp_m[i] = 0;
    recv_m = 0;
    errc_m = 0;
    errf_m = 1'b0;
    sb.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n_i = 1'b0;
    v_i       = 1'b0;
    #1;
    chk("rst_ready", ready_and_o, 0);
    chk("rst_done",  done_o, 0);
    chk("rst_error", error_o, 0);
    chk("rst_errc",  err_count_o, 0);
    chk("rst_recv",  recv_count_o, 0);
    model_clear();
    repeat (2) @(negedge clk);
    reset_n_i = 1'b1;
    #1;
    chk("ready_first_cycle", ready_and_o, 0);
    @(posedge clk);
    #1;
    chk("ready_second_cycle", ready_and_o, 1);
  endtask

  task automatic send_pkt(input logic [3:0] x, input logic [2:0] y, input int src, input int seq);
    exp_t ex;
    exp_t got;
    bit   e;
    bit   acc;
    // reference model of the accept-time checks
    e = (x != MY_X) || (y != MY_Y);
    if (src >= NSRC) e = 1'b1;
    else begin
      if (seq != exp_m[src]) e = 1'b1;
      if (exp_m[src] == PPS) e = 1'b1;
      else exp_m[src]++;
    end
    recv_m++;
    if (e) begin
      errc_m++;
      errf_m = 1'b1;
    end
    ex.recv = 16'(recv_m);
    ex.errc = 16'(errc_m);
    ex.errf = errf_m;
    ex.done = all_done_m();
    sb.push_back(ex);

    @(negedge clk);
    v_i      = 1'b1;
    packet_i = {24'(src), 8'(seq), y, x};
    acc      = 1'b0;
    for (int w = 0; w < 64 && !acc; w++) begin
      if (w > 0) @(negedge clk);
      acc = ready_and_o;
      if (!acc) stalls++;
      @(posedge clk);
      #1;
    end
    v_i = 1'b0;
    if (!acc) chk("accept_timeout", 0, 1);
    got.recv = recv_count_o;
    got.errc = err_count_o;
    got.errf = error_o;
    got.done = done_o;
    ex = sb.pop_front();
    chk("recv_count", got.recv, ex.recv);
    chk("err_count",  got.errc, ex.errc);
    chk("error_flag", got.errf, ex.errf);
    chk("done_flag",  got.done, ex.done);
  endtask

  // Send the first n packets of the in-order set (seq-major across sources),
  // optionally corrupting the y coordinate of the final one.
  task automatic send_set(input int n, input bit bad_last);
    int k;
    k = 0;
    for (int s = 0; s < PPS; s++)
      for (int t = 0; t < NSRC; t++) begin
        if (k < n)
          send_pkt(MY_X, (bad_last && k == NSRC*PPS-1) ? MY_Y + 3'd1 : MY_Y, t, s);
        k++;
      end
  endtask

  initial begin
    int q;
    n_vec      = 0;
    n_err      = 0;
    stalls     = 0;
    reset_n_i  = 1'b0;
    v_i        = 1'b0;
    packet_i   = '0;
    stall_en_i = 1'b0;
    my_x_i     = MY_X;
    my_y_i     = MY_Y;

    // clean in-order traffic, no backpressure
    do_reset();
    stalls = 0;
    send_set(NSRC*PPS, 1'b0);
    chk("s1_stalls", stalls, 0);
    chk("s1_done",   done_o, 1);
    chk("s1_error",  error_o, 0);
    chk("s1_recv",   recv_count_o, 32);

    // same traffic with random backpressure
    stall_en_i = 1'b1;
    do_reset();
    stalls = 0;
    send_set(NSRC*PPS, 1'b0);
    chk("s2_stall_seen", (stalls > 0), 1);
    chk("s2_done",   done_o, 1);
    chk("s2_error",  error_o, 0);
    chk("s2_recv",   recv_count_o, 32);
    stall_en_i = 1'b0;

    // bad x on first packet, source 3 out of order, then post-done traffic
    do_reset();
    for (int s = 0; s < PPS; s++)
      for (int t = 0; t < NSRC; t++) begin
        q = (t == 3) ? perm3[s] : s;
        send_pkt((t == 0 && s == 0) ? MY_X + 4'd1 : MY_X, MY_Y, t, q);
      end
    chk("s3_done",  done_o, 1);
    chk("s3_errc",  err_count_o, 3);
    send_pkt(MY_X, MY_Y, 0, 4);
    send_pkt(MY_X, MY_Y, 8, 0);
    chk("s3_done_hold", done_o, 1);
    chk("s3_errc_end",  err_count_o, 5);

    // completing packet also carries an error: both flags rise together
    do_reset();
    send_set(NSRC*PPS, 1'b1);
    chk("s4_errc", err_count_o, 1);

    // reset mid-stream, then a full clean resend
    do_reset();
    send_set(10, 1'b0);
    @(negedge clk);
    v_i      = 1'b1;
    packet_i = {24'd2, 8'd1, MY_Y, MY_X};
    reset_n_i = 1'b0;
    #1;
    chk("mid_rst_ready", ready_and_o, 0);
    chk("mid_rst_done",  done_o, 0);
    chk("mid_rst_error", error_o, 0);
    chk("mid_rst_errc",  err_count_o, 0);
    chk("mid_rst_recv",  recv_count_o, 0);
    v_i = 1'b0;
    do_reset();
    send_set(NSRC*PPS, 1'b0);
    chk("s5_done",  done_o, 1);
    chk("s5_error", error_o, 0);
    chk("s5_recv",  recv_count_o, 32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
